captura_jogada: RTL and testbench

// Captures a player's button press (8 raw push-buttons) and turns it into a

---
 rtl/captura_jogada.sv | 133 +++++++++++++
 tb/tb_captura_jogada.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/captura_jogada.sv
// rtl/captura_jogada.sv - button capture: 2-FF sync, per-bit debounce, one-hot capture FSM
// Drives the one-hot 7-segment decoder; jogada is always 8'h00 or exactly one-hot.
module captura_jogada #(
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       habilita,
  input  logic       limpa,
  input  logic [7:0] botoes,
  output logic [7:0] jogada,
  output logic       tem_jogada,
  output logic       jogada_feita,
  output logic       erro_multiplo
);

  typedef enum logic [1:0] {ESPERA, PRESSIONADO, LIBERA} estado_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);
  localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);

  logic [7:0]       sinc1_q, sinc_q;
  logic [7:0]       estavel_q, estavel_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  estado_t          estado_q, estado_d;
  logic [7:0]       jogada_q, jogada_d;
  logic             tem_jogada_q, tem_jogada_d;
  logic             feita_q, feita_d;
  logic             erro_q, erro_d;
  logic             algum, unico;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sinc1_q   <= '0;
      sinc_q    <= '0;
      estavel_q <= '0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      sinc1_q   <= botoes;
      sinc_q    <= sinc1_q;
      estavel_q <= estavel_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A bit flips only after DEBOUNCE_CICLOS consecutive cycles of disagreement.
  always_comb begin
    estavel_d = estavel_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (sinc_q[i] != estavel_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          estavel_d[i] = sinc_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_UM;
        end
      end
    end
  end

  assign algum = (estavel_q != 8'd0);
  assign unico = algum && ((estavel_q & (estavel_q - 8'd1)) == 8'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q     <= ESPERA;
      jogada_q     <= '0;
      tem_jogada_q <= 1'b0;
      feita_q      <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      jogada_q     <= jogada_d;
      tem_jogada_q <= tem_jogada_d;
      feita_q      <= feita_d;
      erro_q       <= erro_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    if (limpa) begin
      estado_d = algum ? LIBERA : ESPERA;
    end else begin
      case (estado_q)
        ESPERA: begin
          if (algum) estado_d = (habilita && unico) ? PRESSIONADO : LIBERA;
        end
        PRESSIONADO, LIBERA: begin
          if (!algum) estado_d = ESPERA;
        end
        default: estado_d = ESPERA;
      endcase
    end
  end

  // limpa wins over any capture or release pulse in the same cycle.
  always_comb begin
    jogada_d     = jogada_q;
    tem_jogada_d = tem_jogada_q;
    feita_d      = 1'b0;
    erro_d       = 1'b0;
    if (limpa) begin
      jogada_d     = '0;
      tem_jogada_d = 1'b0;
    end else begin
      case (estado_q)
        ESPERA: begin
          if (algum && habilita) begin
            if (unico) begin
              jogada_d     = estavel_q;
              tem_jogada_d = 1'b1;
            end else begin
              erro_d = 1'b1;
            end
          end
        end
        PRESSIONADO: begin
          if (!algum) feita_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign jogada        = jogada_q;
  assign tem_jogada    = tem_jogada_q;
  assign jogada_feita  = feita_q;
  assign erro_multiplo = erro_q;

endmodule

// File: tb/tb_captura_jogada.sv
// tb/tb_captura_jogada.sv - directed self-checking bench for captura_jogada
module tb_captura_jogada;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       habilita = 1'b0;
  logic       limpa = 1'b0;
  logic [7:0] botoes = 8'h00;
  logic [7:0] jogada;
  logic       tem_jogada, jogada_feita, erro_multiplo;

  int errors = 0;
  int checks = 0;
  int feita_cnt = 0;
  int erro_cnt = 0;
  int both_cnt = 0;
  int bad_hot_cnt = 0;

  captura_jogada #(.DEBOUNCE_CICLOS(4), .CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .habilita(habilita), .limpa(limpa),
    .botoes(botoes), .jogada(jogada), .tem_jogada(tem_jogada),
    .jogada_feita(jogada_feita), .erro_multiplo(erro_multiplo)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (jogada_feita) feita_cnt++;
    if (erro_multiplo) erro_cnt++;
    if (jogada_feita && erro_multiplo) both_cnt++;
    if (jogada != 8'h00 && (jogada & (jogada - 8'd1)) != 8'h00) bad_hot_cnt++;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset_n = 1'b0;
    botoes = 8'h00; limpa = 1'b0; habilita = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    checks++;
    if ({jogada, tem_jogada, jogada_feita, erro_multiplo} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got jogada=%h tem=%b feita=%b erro=%b required all 0",
               jogada, tem_jogada, jogada_feita, erro_multiplo);
    end
  endtask

  task automatic test_capture_latency();
    int f0;
    do_reset();
    f0 = feita_cnt;
    botoes = 8'h04;
    tick(6);
    checks++;
    if (jogada !== 8'h00 || tem_jogada !== 1'b0) begin
      errors++; $display("FAIL capture_early got jogada=%h tem=%b required 00/0", jogada, tem_jogada);
    end
    tick(1);
    checks++;
    if (jogada !== 8'h04 || tem_jogada !== 1'b1) begin
      errors++; $display("FAIL capture_at_7 got jogada=%h tem=%b required 04/1", jogada, tem_jogada);
    end
    tick(13);
    botoes = 8'h00;
    tick(6);
    checks++;
    if (jogada_feita !== 1'b0) begin
      errors++; $display("FAIL feita_early got %b required 0", jogada_feita);
    end
    tick(1);
    checks++;
    if (jogada_feita !== 1'b1) begin
      errors++; $display("FAIL feita_at_7 got %b required 1", jogada_feita);
    end
    tick(5);
    checks++;
    if (feita_cnt - f0 !== 1 || jogada !== 8'h04 || tem_jogada !== 1'b1) begin
      errors++;
      $display("FAIL feita_single got pulses=%0d jogada=%h tem=%b required 1/04/1",
               feita_cnt - f0, jogada, tem_jogada);
    end
  endtask

  task automatic test_glitch();
    int f0, e0;
    do_reset();
    f0 = feita_cnt; e0 = erro_cnt;
    botoes = 8'h10;
    tick(3);
    botoes = 8'h00;
    tick(15);
    checks++;
    if (jogada !== 8'h00 || tem_jogada !== 1'b0 || feita_cnt != f0 || erro_cnt != e0) begin
      errors++;
      $display("FAIL glitch got jogada=%h tem=%b feita=%0d erro=%0d required 00/0/0/0",
               jogada, tem_jogada, feita_cnt - f0, erro_cnt - e0);
    end
  endtask

  task automatic test_multiple();
    int e0;
    do_reset();
    e0 = erro_cnt;
    botoes = 8'h81;
    tick(7);
    checks++;
    if (erro_multiplo !== 1'b1) begin
      errors++; $display("FAIL multi_pulse_at_7 got %b required 1", erro_multiplo);
    end
    tick(5);
    checks++;
    if (erro_cnt - e0 !== 1 || jogada !== 8'h00 || tem_jogada !== 1'b0) begin
      errors++;
      $display("FAIL multi_no_capture got pulses=%0d jogada=%h tem=%b required 1/00/0",
               erro_cnt - e0, jogada, tem_jogada);
    end
    botoes = 8'h00;
    tick(10);
    botoes = 8'h02;
    tick(8);
    checks++;
    if (jogada !== 8'h02 || tem_jogada !== 1'b1) begin
      errors++; $display("FAIL multi_then_single got jogada=%h tem=%b required 02/1", jogada, tem_jogada);
    end
    botoes = 8'h00;
    tick(10);
  endtask

  task automatic test_extra_button();
    int f0, e0;
    do_reset();
    f0 = feita_cnt; e0 = erro_cnt;
    botoes = 8'h01;
    tick(8);
    botoes = 8'h41;
    tick(10);
    checks++;
    if (jogada !== 8'h01 || erro_cnt != e0) begin
      errors++; $display("FAIL extra_held got jogada=%h erro=%0d required 01/0", jogada, erro_cnt - e0);
    end
    botoes = 8'h40;
    tick(10);
    checks++;
    if (feita_cnt != f0 || jogada !== 8'h01) begin
      errors++; $display("FAIL extra_partial got feita=%0d jogada=%h required 0/01", feita_cnt - f0, jogada);
    end
    botoes = 8'h00;
    tick(10);
    checks++;
    if (feita_cnt - f0 !== 1 || jogada !== 8'h01) begin
      errors++; $display("FAIL extra_release got feita=%0d jogada=%h required 1/01", feita_cnt - f0, jogada);
    end
  endtask

  task automatic test_habilita_limpa();
    int f0;
    do_reset();
    habilita = 1'b0;
    botoes = 8'h08;
    tick(10);
    habilita = 1'b1;
    tick(10);
    checks++;
    if (jogada !== 8'h00 || tem_jogada !== 1'b0) begin
      errors++; $display("FAIL disabled_press got jogada=%h tem=%b required 00/0", jogada, tem_jogada);
    end
    botoes = 8'h00;
    tick(10);
    botoes = 8'h08;
    tick(8);
    checks++;
    if (jogada !== 8'h08 || tem_jogada !== 1'b1) begin
      errors++; $display("FAIL repress got jogada=%h tem=%b required 08/1", jogada, tem_jogada);
    end
    f0 = feita_cnt;
    limpa = 1'b1;
    tick(1);
    limpa = 1'b0;
    checks++;
    if (jogada !== 8'h00 || tem_jogada !== 1'b0) begin
      errors++; $display("FAIL limpa got jogada=%h tem=%b required 00/0", jogada, tem_jogada);
    end
    botoes = 8'h00;
    tick(10);
    checks++;
    if (feita_cnt != f0) begin
      errors++; $display("FAIL limpa_drops_feita got pulses=%0d required 0", feita_cnt - f0);
    end
  endtask

  task automatic test_reset_mid_press();
    int f0;
    do_reset();
    botoes = 8'h20;
    tick(8);
    checks++;
    if (jogada !== 8'h20) begin
      errors++; $display("FAIL pre_reset_capture got jogada=%h required 20", jogada);
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({jogada, tem_jogada, jogada_feita, erro_multiplo} !== 11'd0) begin
      errors++; $display("FAIL async_reset got jogada=%h tem=%b required 00/0", jogada, tem_jogada);
    end
    tick(2);
    f0 = feita_cnt;
    reset_n = 1'b1;
    tick(2);
    botoes = 8'h00;
    tick(15);
    checks++;
    if (feita_cnt != f0 || jogada !== 8'h00 || tem_jogada !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_feita got pulses=%0d jogada=%h tem=%b required 0/00/0",
               feita_cnt - f0, jogada, tem_jogada);
    end
    botoes = 8'h20;
    tick(8);
    @(negedge clock);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(6);
    checks++;
    if (jogada !== 8'h00) begin
      errors++; $display("FAIL held_after_reset_early got jogada=%h required 00", jogada);
    end
    tick(1);
    checks++;
    if (jogada !== 8'h20 || tem_jogada !== 1'b1) begin
      errors++; $display("FAIL held_after_reset_debounced got jogada=%h tem=%b required 20/1", jogada, tem_jogada);
    end
    botoes = 8'h00;
    tick(10);
  endtask

  task automatic test_invariants();
    checks++;
    if (both_cnt != 0 || bad_hot_cnt != 0) begin
      errors++;
      $display("FAIL invariants got both_high=%0d not_onehot=%0d required 0/0", both_cnt, bad_hot_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_capture_latency();
    test_glitch();
    test_multiple();
    test_extra_button();
    test_habilita_limpa();
    test_reset_mid_press();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
